// File: rtl/hdmi_video_timing.sv
// Video timing controller: pixel strobe divider, raster counters, pixel fetch
// handshake and a registered sync/DE/RGB output stage for the TMDS encoder.
module hdmi_video_timing #(
   parameter int   H_ACTIVE  = 640,
   parameter int   H_FP      = 16,
   parameter int   H_SYNC    = 96,
   parameter int   H_BP      = 48,
   parameter int   V_ACTIVE  = 480,
   parameter int   V_FP      = 10,
   parameter int   V_SYNC    = 2,
   parameter int   V_BP      = 33,
   parameter logic HSYNC_POL = 1'b0,
   parameter logic VSYNC_POL = 1'b0,
   parameter int   PIX_DIV   = 5
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        en,
   output logic        req,
   output logic [9:0]  req_x,
   output logic [9:0]  req_y,
   input  logic [23:0] rgb_in,
   input  logic        rgb_valid,
   output logic        pix_ce,
   output logic        hsync,
   output logic        vsync,
   output logic        de,
   output logic [23:0] rgb_out,
   output logic        frame_start,
   output logic        underflow
);

   localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
   localparam int DW      = (PIX_DIV > 1) ? $clog2(PIX_DIV) : 1;

   logic [DW-1:0] div_r;
   logic [9:0]    hc_r;
   logic [9:0]    vc_r;
   logic          win_r;
   logic          got_r;
   logic [23:0]   hold_r;
   logic          prev_act_r;
   logic          prev_hs_r;
   logic          prev_vs_r;

   logic          tick_s;
   logic          act_s;
   logic          hs_s;
   logic          vs_s;
   logic          hc_last_s;
   logic          vc_last_s;
   logic          cap_s;
   logic          got_s;
   logic [23:0]   pix_s;

   assign tick_s    = (div_r == DW'(PIX_DIV - 1));
   assign act_s     = (hc_r < 10'(H_ACTIVE)) && (vc_r < 10'(V_ACTIVE));
   assign hs_s      = (hc_r >= 10'(H_ACTIVE + H_FP)) && (hc_r < 10'(H_ACTIVE + H_FP + H_SYNC));
   assign vs_s      = (vc_r >= 10'(V_ACTIVE + V_FP)) && (vc_r < 10'(V_ACTIVE + V_FP + V_SYNC));
   assign hc_last_s = (hc_r == 10'(H_TOTAL - 1));
   assign vc_last_s = (vc_r == 10'(V_TOTAL - 1));

   // The window opens after a req and excludes the strobe cycles; a valid on
   // the closing clk still counts toward the pixel emitted on that tick.
   assign cap_s = rgb_valid && win_r && !pix_ce;
   assign got_s = got_r || cap_s;
   assign pix_s = cap_s ? rgb_in : hold_r;

   // Divider, raster counters, fetch handshake and output stage.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         div_r       <= '0;
         hc_r        <= 10'd0;
         vc_r        <= 10'd0;
         win_r       <= 1'b0;
         got_r       <= 1'b0;
         hold_r      <= 24'd0;
         prev_act_r  <= 1'b0;
         prev_hs_r   <= 1'b0;
         prev_vs_r   <= 1'b0;
         req         <= 1'b0;
         req_x       <= 10'd0;
         req_y       <= 10'd0;
         pix_ce      <= 1'b0;
         hsync       <= ~HSYNC_POL;
         vsync       <= ~VSYNC_POL;
         de          <= 1'b0;
         rgb_out     <= 24'd0;
         frame_start <= 1'b0;
         underflow   <= 1'b0;
      end else if (!en) begin
         div_r       <= '0;
         hc_r        <= 10'd0;
         vc_r        <= 10'd0;
         win_r       <= 1'b0;
         got_r       <= 1'b0;
         hold_r      <= 24'd0;
         prev_act_r  <= 1'b0;
         prev_hs_r   <= 1'b0;
         prev_vs_r   <= 1'b0;
         req         <= 1'b0;
         req_x       <= 10'd0;
         req_y       <= 10'd0;
         pix_ce      <= 1'b0;
         hsync       <= ~HSYNC_POL;
         vsync       <= ~VSYNC_POL;
         de          <= 1'b0;
         rgb_out     <= 24'd0;
         frame_start <= 1'b0;
      end else begin
         pix_ce      <= tick_s;
         req         <= 1'b0;
         frame_start <= 1'b0;
         if (tick_s) begin
            div_r       <= '0;
            req         <= act_s;
            frame_start <= act_s && (hc_r == 10'd0) && (vc_r == 10'd0);
            if (act_s) begin
               req_x <= hc_r;
               req_y <= vc_r;
            end
            win_r      <= act_s;
            got_r      <= 1'b0;
            hold_r     <= pix_s;
            // The output stage shows the pixel requested on the previous tick.
            prev_act_r <= act_s;
            prev_hs_r  <= hs_s;
            prev_vs_r  <= vs_s;
            de         <= prev_act_r;
            hsync      <= prev_hs_r ? HSYNC_POL : ~HSYNC_POL;
            vsync      <= prev_vs_r ? VSYNC_POL : ~VSYNC_POL;
            rgb_out    <= (prev_act_r && got_s) ? pix_s : 24'd0;
            if (prev_act_r && !got_s) begin
               underflow <= 1'b1;
            end
            if (hc_last_s) begin
               hc_r <= 10'd0;
               vc_r <= vc_last_s ? 10'd0 : vc_r + 10'd1;
            end else begin
               hc_r <= hc_r + 10'd1;
            end
         end else begin
            div_r <= div_r + DW'(1);
            if (cap_s) begin
               hold_r <= rgb_in;
               got_r  <= 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_hdmi_video_timing.sv
// Bench for hdmi_video_timing on a reduced 15x8 raster (8x4 active), PIX_DIV=5:
// strobe-indexed vector table plus hand sequences for late/dup/en/rst cases.
module tb_hdmi_video_timing;

   localparam int HT = 15;
   localparam int VT = 8;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        en  = 1'b1;
   logic        req;
   logic [9:0]  req_x;
   logic [9:0]  req_y;
   logic [23:0] rgb_in = 24'd0;
   logic        rgb_valid = 1'b0;
   logic        pix_ce;
   logic        hsync;
   logic        vsync;
   logic        de;
   logic [23:0] rgb_out;
   logic        frame_start;
   logic        underflow;

   hdmi_video_timing #(
      .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
      .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
      .HSYNC_POL(1'b0), .VSYNC_POL(1'b0), .PIX_DIV(5)
   ) dut (
      .clk(clk), .rst(rst), .en(en),
      .req(req), .req_x(req_x), .req_y(req_y),
      .rgb_in(rgb_in), .rgb_valid(rgb_valid),
      .pix_ce(pix_ce), .hsync(hsync), .vsync(vsync), .de(de),
      .rgb_out(rgb_out), .frame_start(frame_start), .underflow(underflow)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   int s_cnt  = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
      end
   endtask

   // Pixel source: answers 2 clks after req, with late/duplicate/spurious modes.
   int          late_x = -1, late_y = -1, dup_x = -1, dup_y = -1;
   bit          spur_on = 1'b0;
   bit          have = 1'b0;
   int          age = 0;
   logic [9:0]  cx = 10'd0, cy = 10'd0;
   initial begin
      forever begin
         @(negedge clk);
         rgb_valid = 1'b0;
         rgb_in    = 24'd0;
         if (have) begin
            age++;
            if (int'(cx) == late_x && int'(cy) == late_y) begin
               if (age == 5) begin rgb_valid = 1'b1; rgb_in = {cx[7:0], cy[7:0], 8'hA5}; end
            end else if (int'(cx) == dup_x && int'(cy) == dup_y) begin
               if (age == 1) begin rgb_valid = 1'b1; rgb_in = 24'hDEAD00; end
               if (age == 3) begin rgb_valid = 1'b1; rgb_in = {cx[7:0], cy[7:0], 8'hA5}; end
            end else if (age == 2) begin
               rgb_valid = 1'b1; rgb_in = {cx[7:0], cy[7:0], 8'hA5};
            end
            if (spur_on && age == 12) begin rgb_valid = 1'b1; rgb_in = 24'hFFFFFF; end
         end
         if (req) begin have = 1'b1; age = 0; cx = req_x; cy = req_y; end
      end
   end

   // Frame monitor: reference raster model indexed by strobe number.
   bit mon_on = 1'b0;
   int mon_n = 0, mon_de = 0, mon_hs = 0, mon_vs = 0, mon_bad = 0;
   initial begin
      forever begin
         @(negedge clk);
         if (mon_on && pix_ce) begin
            int p, px, py;
            logic exp_de;
            logic [23:0] exp_rgb;
            logic [7:0] bx, by;
            p  = mon_n - 1;
            px = (p < 0) ? 0 : p % HT;
            py = (p < 0) ? 0 : (p / HT) % VT;
            exp_de = (p >= 0) && (px < 8) && (py < 4);
            bx = 8'(px);
            by = 8'(py);
            exp_rgb = exp_de ? {bx, by, 8'hA5} : 24'd0;
            if (de !== exp_de || rgb_out !== exp_rgb) mon_bad++;
            if (de) mon_de++;
            if (!hsync) mon_hs++;
            if (!vsync) mon_vs++;
            mon_n++;
         end
      end
   end

   task automatic wait_strobe(input int target);
      bit ok;
      ok = 1'b0;
      for (int k = 0; k < 5000 && !ok; k++) begin
         @(negedge clk);
         if (pix_ce) begin
            if (s_cnt == target) ok = 1'b1;
            s_cnt++;
         end
      end
      chk($sformatf("reach_strobe_%0d", target), {31'd0, ok}, 32'd1);
   endtask

   task automatic first_strobe(input string nm);
      int edges;
      edges = 99;
      for (int k = 1; k <= 20; k++) begin
         @(negedge clk);
         if (pix_ce) begin edges = k; break; end
      end
      s_cnt = 1;
      chk({nm, "_first_ce_edge"}, edges, 32'd5);
      chk({nm, "_req"}, req, 32'd1);
      chk({nm, "_req_x"}, req_x, 32'd0);
      chk({nm, "_req_y"}, req_y, 32'd0);
      chk({nm, "_frame_start"}, frame_start, 32'd1);
   endtask

   task automatic reset_chk(input string nm);
      chk({nm, "_hsync"}, hsync, 32'd1);
      chk({nm, "_vsync"}, vsync, 32'd1);
      chk({nm, "_de"}, de, 32'd0);
      chk({nm, "_rgb_out"}, rgb_out, 32'd0);
      chk({nm, "_req"}, req, 32'd0);
      chk({nm, "_req_xy"}, {req_x, req_y}, 32'd0);
      chk({nm, "_pix_ce"}, pix_ce, 32'd0);
      chk({nm, "_frame_start"}, frame_start, 32'd0);
      chk({nm, "_underflow"}, underflow, 32'd0);
   endtask

   typedef struct {
      int          strobe;
      logic        req;
      logic [9:0]  x;
      logic [9:0]  y;
      logic        fs;
      logic        de;
      logic        hs;
      logic        vs;
      logic [23:0] rgb;
   } row_t;

   row_t rows [13];

   initial begin
      rows[0]  = '{0,   1'b1, 10'd0, 10'd0, 1'b1, 1'b0, 1'b1, 1'b1, 24'h000000};
      rows[1]  = '{1,   1'b1, 10'd1, 10'd0, 1'b0, 1'b1, 1'b1, 1'b1, 24'h0000A5};
      rows[2]  = '{8,   1'b0, 10'd7, 10'd0, 1'b0, 1'b1, 1'b1, 1'b1, 24'h0700A5};
      rows[3]  = '{9,   1'b0, 10'd7, 10'd0, 1'b0, 1'b0, 1'b1, 1'b1, 24'h000000};
      rows[4]  = '{11,  1'b0, 10'd7, 10'd0, 1'b0, 1'b0, 1'b0, 1'b1, 24'h000000};
      rows[5]  = '{13,  1'b0, 10'd7, 10'd0, 1'b0, 1'b0, 1'b0, 1'b1, 24'h000000};
      rows[6]  = '{14,  1'b0, 10'd7, 10'd0, 1'b0, 1'b0, 1'b1, 1'b1, 24'h000000};
      rows[7]  = '{15,  1'b1, 10'd0, 10'd1, 1'b0, 1'b0, 1'b1, 1'b1, 24'h000000};
      rows[8]  = '{76,  1'b0, 10'd7, 10'd3, 1'b0, 1'b0, 1'b1, 1'b0, 24'h000000};
      rows[9]  = '{105, 1'b0, 10'd7, 10'd3, 1'b0, 1'b0, 1'b1, 1'b0, 24'h000000};
      rows[10] = '{106, 1'b0, 10'd7, 10'd3, 1'b0, 1'b0, 1'b1, 1'b1, 24'h000000};
      rows[11] = '{120, 1'b1, 10'd0, 10'd0, 1'b1, 1'b0, 1'b1, 1'b1, 24'h000000};
      rows[12] = '{121, 1'b1, 10'd1, 10'd0, 1'b0, 1'b1, 1'b1, 1'b1, 24'h0000A5};

      repeat (3) @(negedge clk);
      reset_chk("reset");
      mon_on = 1'b1;
      rst = 1'b0;
      first_strobe("start");
      for (int i = 0; i < 13; i++) begin
         if (i > 0) wait_strobe(rows[i].strobe);
         chk($sformatf("row%0d_req", i), req, rows[i].req);
         chk($sformatf("row%0d_req_xy", i), {req_x, req_y}, {rows[i].x, rows[i].y});
         chk($sformatf("row%0d_frame_start", i), frame_start, rows[i].fs);
         chk($sformatf("row%0d_de", i), de, rows[i].de);
         chk($sformatf("row%0d_hsync", i), hsync, rows[i].hs);
         chk($sformatf("row%0d_vsync", i), vsync, rows[i].vs);
         chk($sformatf("row%0d_rgb_out", i), rgb_out, rows[i].rgb);
      end

      wait_strobe(239);
      @(posedge clk);
      mon_on = 1'b0;
      chk("frames_strobes", mon_n, 32'd240);
      chk("frames_de_count", mon_de, 32'd64);
      chk("frames_hsync_low", mon_hs, 32'd48);
      chk("frames_vsync_low", mon_vs, 32'd60);
      chk("frames_pixel_errs", mon_bad, 32'd0);
      chk("frames_underflow", underflow, 32'd0);

      late_x = 5; late_y = 2; dup_x = 2; dup_y = 3; spur_on = 1'b1;
      wait_strobe(275);
      chk("late_req_xy", {req_x, req_y}, {10'd5, 10'd2});
      chk("late_prev_rgb", rgb_out, 32'h0402A5);
      chk("late_prev_underflow", underflow, 32'd0);
      wait_strobe(276);
      chk("late_de", de, 32'd1);
      chk("late_rgb", rgb_out, 32'd0);
      chk("late_underflow", underflow, 32'd1);
      wait_strobe(277);
      chk("late_next_rgb", rgb_out, 32'h0602A5);
      wait_strobe(288);
      chk("dup_de", de, 32'd1);
      chk("dup_rgb_last_wins", rgb_out, 32'h0203A5);
      wait_strobe(295);
      chk("spur_de", de, 32'd0);
      chk("spur_rgb", rgb_out, 32'd0);
      chk("spur_underflow_sticky", underflow, 32'd1);
      late_x = -1; late_y = -1; dup_x = -1; dup_y = -1; spur_on = 1'b0;

      wait_strobe(379);
      chk("en_req_xy", {req_x, req_y}, {10'd4, 10'd1});
      en = 1'b0;
      @(negedge clk);
      chk("en_idle_pix_ce", pix_ce, 32'd0);
      chk("en_idle_req", req, 32'd0);
      chk("en_idle_req_xy", {req_x, req_y}, 32'd0);
      chk("en_idle_de", de, 32'd0);
      chk("en_idle_rgb", rgb_out, 32'd0);
      chk("en_idle_syncs", {hsync, vsync}, 32'd3);
      chk("en_idle_underflow_kept", underflow, 32'd1);
      begin
         int seen;
         seen = 0;
         for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (pix_ce || req) seen++;
         end
         chk("en_low_quiet", seen, 32'd0);
      end
      en = 1'b1;
      first_strobe("en_restart");

      wait_strobe(56);
      chk("rst_pre_req_xy", {req_x, req_y}, {10'd7, 10'd3});
      chk("rst_pre_underflow", underflow, 32'd1);
      rst = 1'b1;
      #1;
      reset_chk("mid_rst");
      @(negedge clk);
      rst = 1'b0;
      first_strobe("rst_restart");
      wait_strobe(16);
      chk("rst_restart_de", de, 32'd1);
      chk("rst_restart_rgb", rgb_out, 32'h0001A5);
      chk("rst_restart_underflow", underflow, 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/hdmi_video_timing.md
# hdmi_video_timing

Video timing controller that schedules the HDMI pixel datapath. It divides the system clock down to a pixel strobe and generates 640x480@60 sync and data-enable timing by default. It fetches each active pixel from a requester through a request/valid handshake and presents registered RGB, hsync, vsync and DE to the TMDS encoder. It sits between the user design and the TMDS encoder/serializer in the HDMI output path.

## Interface
- H_ACTIVE, 640, active pixels per line
- H_FP, 16, horizontal front porch (pixels)
- H_SYNC, 96, hsync width (pixels)
- H_BP, 48, horizontal back porch (pixels)
- V_ACTIVE, 480, active lines
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vsync width (lines)
- V_BP, 33, vertical back porch (lines)
- HSYNC_POL, 0, active level of hsync
- VSYNC_POL, 0, active level of vsync
- PIX_DIV, 5, clk cycles per pixel; must be ≥2
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- en  in  1  run enable; low holds the block idle
- req  out  1  one-clk pixel request pulse
- req_x  out  10  x coordinate of the requested pixel
- req_y  out  10  y coordinate of the requested pixel
- rgb_in  in  24  pixel data from the requester, {R,G,B}
- rgb_valid  in  1  rgb_in qualifier
- pix_ce  out  1  one-clk pixel strobe
- hsync  out  1  horizontal sync
- vsync  out  1  vertical sync
- de  out  1  data enable
- rgb_out  out  24  pixel to the encoder
- frame_start  out  1  one-clk pulse at the request for pixel (0,0)
- underflow  out  1  sticky flag: a pixel arrived late

## Operation
- Divider counter `div` runs 0..PIX_DIV-1. pix_ce is registered and high for exactly one clk when `div` wraps: one pulse every PIX_DIV clks.
- Line totals: H_TOTAL = sum of the four H_* parameters (800). V_TOTAL = sum of the four V_* parameters (525).
- Counters:
  - hc advances on pix_ce and wraps at H_TOTAL-1 → 0.
  - vc increments when hc wraps and itself wraps at V_TOTAL-1 → 0.
  - Both wrap in the same strobe at (799,524).
- Active region: hc < H_ACTIVE and vc < V_ACTIVE.
- Sync regions:
  - hsync is at its active level for H_ACTIVE+H_FP ≤ hc < H_ACTIVE+H_FP+H_SYNC (656..751).
  - vsync is at its active level for V_ACTIVE+V_FP ≤ vc < V_ACTIVE+V_FP+V_SYNC (490..491).
  - Both are at their inactive level otherwise.
- Request:
  - On each pix_ce where the current (hc,vc) is active, pulse req with req_x=hc and req_y=vc.
  - req_x/req_y hold until the next req.
  - frame_start pulses with the req for (0,0).
- Capture window: the clk cycles strictly after the req pulse and before the next pix_ce (PIX_DIV-1 cycles).
  - rgb_valid inside the window latches rgb_in into a hold register and sets `got`. If several arrive, the last one wins.
  - rgb_valid outside any window, or coincident with pix_ce, is ignored.
- Output stage, updated only on pix_ce, from the (hc,vc) of the previous strobe:
  - de = active.
  - hsync and vsync take their decoded levels.
  - If active and `got`: rgb_out = hold.
  - If active and not `got`: rgb_out = 0 and underflow is set.
  - Blanking: rgb_out = 0.
  - `got` clears on every pix_ce.
- en low, sampled each clk, synchronously clears `div`, hc, vc, the hold register and `got`.
  - Outputs go to reset values on the next clk; req and pix_ce stay 0.
  - underflow is retained.
  - On en rising, timing restarts at (0,0). The first pix_ce comes PIX_DIV clks after the first en-high clk.
- underflow clears only on rst.
- Reset values:
  - hsync = ~HSYNC_POL, vsync = ~VSYNC_POL.
  - de, rgb_out, req, req_x, req_y, pix_ce, frame_start and underflow = 0.
  - Internal counters = 0.

## Timing
- Reset is asynchronous assert. All outputs are registered on clk.
- First pix_ce comes on the PIX_DIV-th rising edge after rst deasserts, with en high.
- Latency from req to the corresponding de/rgb_out is exactly PIX_DIV clks (one pixel). Sync outputs carry the same one-pixel lag.
- Line period is H_TOTAL·PIX_DIV clks (4000). Frame period is H_TOTAL·V_TOTAL·PIX_DIV clks (2,100,000).
- Reset asserted mid-frame forces reset values immediately. After release, timing restarts at (0,0) with no partial line.

## Test plan
- Reset: hold rst, then check hsync=1, vsync=1 and every other output 0. Release with en=1: first pix_ce on clk edge 5, and req/frame_start with req_x=0, req_y=0 on that same edge.
- Full frame with a source that answers rgb_valid 2 clks after req with rgb_in={x[7:0],y[7:0],8'hA5}:
  - exactly 307,200 de-high strobes, every rgb_out matching the pixel requested one strobe earlier;
  - hsync low for 96 strobes every 800, vsync low for 1600 strobes (2 lines);
  - underflow stays 0.
- Late source (valid coincident with pix_ce) at pixel (10,3): rgb_out=0 for that pixel and underflow=1 and stays 1. Neighbouring pixels are unaffected.
- Spurious rgb_valid during blanking (hc=700) and duplicate valids in one window: blanking rgb_out stays 0, and the last value in the window is output.
- en dropped at (320,100) for 7 clks, then raised: outputs go idle the next clk, and req for (0,0) plus frame_start follow 5 clks after en rises.
- rst pulsed mid-line at (500,200) with underflow=1: all outputs, including underflow, return to reset values immediately, then timing restarts at (0,0).
